// File: rtl/param_processor_pkg.sv
// Shared opcode values, FSM state encoding and flag bit positions for the
// parametrised accumulator processor.
package param_processor_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_LDR = 4'd12;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_illegal(input logic [3:0] opc);
    return opc > OP_LDR;
  endfunction

endpackage

// File: rtl/param_processor_alu.sv
// Combinational single-cycle ALU: computes the accumulator result and the
// updated {N,V,C,Z} flags for every opcode except the iterative multiply.
module ppu_alu
  import param_processor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] r,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_out,
  output logic              acc_we
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;

  // Flags not touched by an opcode fall through from flags_in; N and Z
  // follow every result that lands in the accumulator.
  always_comb begin
    wide      = '0;
    result    = '0;
    flags_out = flags_in;
    acc_we    = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide              = {1'b0, a} + {1'b0, b};
        result            = wide[MSB:0];
        flags_out[FLAG_C] = wide[DATA_W];
        flags_out[FLAG_V] = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
        acc_we            = 1'b1;
      end
      OP_SUB: begin
        wide              = {1'b0, a} - {1'b0, b};
        result            = wide[MSB:0];
        flags_out[FLAG_C] = ~wide[DATA_W];
        flags_out[FLAG_V] = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
        acc_we            = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (opcode == OP_AND)     result = a & b;
        else if (opcode == OP_OR) result = a | b;
        else                      result = a ^ b;
        flags_out[FLAG_C] = 1'b0;
        flags_out[FLAG_V] = 1'b0;
        acc_we            = 1'b1;
      end
      OP_NOT: begin
        result = ~a;
        acc_we = 1'b1;
      end
      OP_SHL: begin
        result            = {a[MSB-1:0], 1'b0};
        flags_out[FLAG_C] = a[MSB];
        flags_out[FLAG_V] = 1'b0;
        acc_we            = 1'b1;
      end
      OP_SHR: begin
        result            = {1'b0, a[MSB:1]};
        flags_out[FLAG_C] = a[0];
        flags_out[FLAG_V] = 1'b0;
        acc_we            = 1'b1;
      end
      OP_LDI: begin
        result = b;
        acc_we = 1'b1;
      end
      OP_LDR: begin
        result = r;
        acc_we = 1'b1;
      end
      OP_NOP, OP_MOV, OP_MUL: acc_we = 1'b0;
      default:                acc_we = 1'b0;
    endcase
    if (acc_we) begin
      flags_out[FLAG_N] = result[MSB];
      flags_out[FLAG_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/param_processor.sv
// Width-generic accumulator processor: instruction register, register file,
// shift-add multiplier and a busy/done handshake toward an external sequencer.
module param_processor
  import param_processor_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int INSTR_W  = 5 + RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op,
  input  logic [INSTR_W-1:0] instruction,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  acc_out,
  output logic [3:0]         flags,
  output logic               illegal
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               illegal_q, busy_q, done_q;

  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [2*DATA_W-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_step;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0]        opcode;
  logic              src_acc;
  logic [RA_W-1:0]   rs;
  logic [DATA_W-1:0] imm, op_a, reg_val, alu_result;
  logic [3:0]        alu_flags;
  logic              alu_acc_we, mul_last;

  assign opcode  = ir_q[INSTR_W-1 -: 4];
  assign src_acc = ir_q[DATA_W+RA_W];
  assign rs      = ir_q[DATA_W +: RA_W];
  assign imm     = ir_q[DATA_W-1:0];
  assign reg_val = regs_q[rs];
  assign op_a    = src_acc ? acc_q : reg_val;

  ppu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode   (opcode),
    .a        (op_a),
    .b        (imm),
    .r        (reg_val),
    .flags_in (flags_q),
    .result   (alu_result),
    .flags_out(alu_flags),
    .acc_we   (alu_acc_we)
  );

  assign prod_step = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mul_last  = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (op) begin
          ir_q      <= instruction;
          illegal_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_illegal(opcode)) illegal_q <= 1'b1;
          if (opcode == OP_MUL) begin
            state_q <= ST_MUL;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_MUL: if (mul_last) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The multiplier walks the multiplier LSB-first, so the product is complete
  // on the last MUL edge and is committed straight from prod_step.
  always_comb begin
    acc_d    = acc_q;
    flags_d  = flags_q;
    regs_d   = regs_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_EXEC: begin
        if (alu_acc_we) acc_d = alu_result;
        flags_d = alu_flags;
        if (opcode == OP_MOV) regs_d[rs] = acc_q;
        if (opcode == OP_MUL) begin
          mcand_d  = {{DATA_W{1'b0}}, op_a};
          mplier_d = imm;
          prod_d   = '0;
          cnt_d    = CNT_W'(DATA_W);
        end
      end
      ST_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (mul_last) begin
          acc_d           = prod_step[DATA_W-1:0];
          flags_d[FLAG_N] = prod_step[DATA_W-1];
          flags_d[FLAG_Z] = (prod_step[DATA_W-1:0] == '0);
          flags_d[FLAG_C] = |prod_step[2*DATA_W-1:DATA_W];
          flags_d[FLAG_V] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      regs_q   <= regs_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_out = acc_q;
  assign flags   = flags_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_param_processor.sv
// Randomised self-checking bench for param_processor (DATA_W=8, NUM_REGS=4),
// compared against an arithmetic reference model of the instruction set.
module tb_param_processor;

  logic        clk;
  logic        reset;
  logic        op;
  logic [14:0] instruction;
  logic        busy, done, illegal;
  logic [7:0]  acc_out;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  int       m_acc;
  int       m_regs [4];
  bit [3:0] m_flags;
  bit       m_illegal;

  param_processor #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .instruction(instruction),
    .busy       (busy),
    .done       (done),
    .acc_out    (acc_out),
    .flags      (flags),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic void model_nz(input int r);
    m_acc      = r & 255;
    m_flags[3] = (m_acc >= 128);
    m_flags[0] = (m_acc == 0);
  endfunction

  // Reference model: plain integer arithmetic over unsigned 0..255 values,
  // flags packed as {N,V,C,Z}.
  function automatic void model_exec(input int opc, input int sa, input int rs, input int imm);
    int a, s;
    a = sa ? m_acc : m_regs[rs];
    m_illegal = 1'b0;
    case (opc)
      0: ;
      1: begin
        s = to_signed8(a) + to_signed8(imm);
        m_flags[1] = (a + imm) > 255;
        m_flags[2] = (s > 127) || (s < -128);
        model_nz(a + imm);
      end
      2: begin
        s = to_signed8(a) - to_signed8(imm);
        m_flags[1] = (a >= imm);
        m_flags[2] = (s > 127) || (s < -128);
        model_nz(a - imm + 256);
      end
      3, 4, 5: begin
        m_flags[1] = 1'b0;
        m_flags[2] = 1'b0;
        if (opc == 3)      model_nz(a & imm);
        else if (opc == 4) model_nz(a | imm);
        else               model_nz(a ^ imm);
      end
      6: model_nz(255 - a);
      7: begin
        m_flags[1] = (a >= 128);
        m_flags[2] = 1'b0;
        model_nz(a * 2);
      end
      8: begin
        m_flags[1] = (a % 2) == 1;
        m_flags[2] = 1'b0;
        model_nz(a / 2);
      end
      9: begin
        m_flags[1] = (a * imm) >= 256;
        m_flags[2] = 1'b0;
        model_nz(a * imm);
      end
      10: model_nz(imm);
      11: m_regs[rs] = m_acc;
      12: model_nz(m_regs[rs]);
      default: m_illegal = 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    m_acc     = 0;
    m_flags   = '0;
    m_illegal = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endfunction

  // Issues one instruction and follows it to its done pulse. Latency counts
  // rising edges after the accept edge until done is seen: one for a single
  // cycle op, nine (EXEC plus eight MUL cycles) for a multiply. With hold set,
  // op stays high and the instruction keeps changing until done shows.
  task automatic applyStimulus(input int opc, input int sa, input int rs, input int imm, input bit hold);
    int lat;
    bit busy_ok;
    @(negedge clk);
    op          = 1'b1;
    instruction = {opc[3:0], sa[0], rs[1:0], imm[7:0]};
    @(posedge clk);
    model_exec(opc, sa, rs, imm);
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    if (hold) instruction = {4'd10, 1'b0, 2'd0, imm[7:0] ^ 8'hFF};
    else      op = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (hold) instruction = {4'd1, 1'b1, 2'd1, 8'(lat)};
    end
    op = 1'b0;
    checkOutput("done_latency", lat, (opc == 9) ? 9 : 1);
    checkOutput("busy_while_running", busy_ok, 1);
    checkOutput("busy_at_done", busy, 0);
    checkOutput("acc", acc_out, m_acc);
    checkOutput("flags", flags, m_flags);
    checkOutput("illegal", illegal, m_illegal);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
  endtask

  // Starts a multiply, pulls reset during its fourth MUL cycle and confirms
  // everything returns to the reset state with no done pulse afterwards.
  task automatic reset_during_mul();
    bit done_seen;
    @(negedge clk);
    op          = 1'b1;
    instruction = {4'd9, 1'b1, 2'd0, 8'h03};
    @(posedge clk);
    @(negedge clk);
    op = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("abort_acc", acc_out, 0);
    checkOutput("abort_flags", flags, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    @(negedge clk);
    reset     = 1'b1;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    checkOutput("no_done_after_abort", done_seen, 0);
  endtask

  initial begin
    reset       = 1'b0;
    op          = 1'b0;
    instruction = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_acc", acc_out, 0);
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_illegal", illegal, 0);
    reset = 1'b1;

    // Signed overflow into the sign bit
    applyStimulus(10, 0, 0, 8'h7F, 1'b0);
    applyStimulus(1, 1, 0, 8'h01, 1'b0);
    checkOutput("add_overflow_acc", acc_out, 8'h80);
    checkOutput("add_overflow_flags", flags, 4'b1100);

    // Equal subtraction, then a shift that carries out
    applyStimulus(10, 0, 0, 8'h05, 1'b0);
    applyStimulus(2, 1, 0, 8'h05, 1'b0);
    applyStimulus(10, 0, 0, 8'h81, 1'b0);
    applyStimulus(7, 1, 0, 8'h00, 1'b0);
    checkOutput("shl_acc", acc_out, 8'h02);

    // Multiply from a register loaded through MOV
    applyStimulus(10, 0, 0, 8'h0C, 1'b0);
    applyStimulus(11, 0, 2, 8'h00, 1'b0);
    applyStimulus(10, 0, 0, 8'h00, 1'b0);
    applyStimulus(9, 0, 2, 8'h15, 1'b0);
    checkOutput("mul_acc", acc_out, 8'hFC);
    applyStimulus(10, 0, 0, 8'hF0, 1'b0);
    applyStimulus(9, 1, 0, 8'h13, 1'b0);

    // Undefined opcode, then recovery
    applyStimulus(14, 1, 0, 8'h00, 1'b0);
    applyStimulus(10, 0, 0, 8'h00, 1'b0);

    // op held high with a changing instruction
    applyStimulus(10, 0, 0, 8'h33, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("held_op_single_exec_acc", acc_out, 8'h33);
    checkOutput("held_op_idle_busy", busy, 0);

    reset_during_mul();
    applyStimulus(10, 0, 0, 8'h5A, 1'b0);

    for (int n = 0; n < 60; n++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 255), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
